// File: rtl/adder27_share_sched.sv
// Round-robin scheduler sharing one pipelined 27-input adder among requesters.
// Tracks vector ownership through the adder with a tag pipe and returns sums.
//
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   req_valid      per-requester vector valid
//   req_data       packed vectors, requester r at [r*NUM_INPUTS*bitsize +: ...]
//   req_ready      one-hot grant
//   adder_in       registered vector into the shared adder
//   adder_sum      adder sum output
//   adder_valid    adder data valid
//   rsp_valid      one-hot one-cycle response pulse for the sum's owner
//   rsp_sum        registered sum, valid with rsp_valid
//   flush          level request to stop granting and drain
//   drain_done     high while draining with an empty pipe
//   busy           high while any tag stage is valid
//   err_lat        sticky adder_valid mismatch (ADDER27_SCHED_PRIO_EN only)
//
// Optional feature macro: ADDER27_SCHED_PRIO_EN (requester 0 fixed priority,
// err_lat output). Undefined: pure round-robin, no err_lat.
module adder27_share_sched #(
    parameter int bitsize       = 14,
    parameter int NUM_INPUTS    = 27,
    parameter int NUM_REQ       = 4,
    parameter int ADDER_LATENCY = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*NUM_INPUTS*bitsize-1:0] req_data,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_INPUTS*bitsize-1:0]         adder_in,
    input  logic [bitsize-1:0]                    adder_sum,
    input  logic                                  adder_valid,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [bitsize-1:0]                    rsp_sum,
    input  logic                                  flush,
    output logic                                  drain_done,
    output logic                                  busy
`ifdef ADDER27_SCHED_PRIO_EN
    ,
    output logic                                  err_lat
`endif
);

    localparam int VW    = NUM_INPUTS * bitsize;
    localparam int DEPTH = ADDER_LATENCY + 1;
    localparam int IDW   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     win;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] grant;
    logic               grant_en;
    logic               xfer;
    logic [DEPTH-1:0]   tag_v;
    logic [IDW-1:0]     tag_id [DEPTH];
    logic               err_q;
    int                 j;

`ifdef ADDER27_SCHED_PRIO_EN
    assign cand = {req_valid[NUM_REQ-1:1], 1'b0};
`else
    assign cand = req_valid;
`endif

    // Reverse scan: the lowest offset from the pointer is written last and wins.
    always_comb begin
        grant = '0;
        win   = '0;
        j     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (cand[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                win      = IDW'(j);
            end
        end
`ifdef ADDER27_SCHED_PRIO_EN
        if (req_valid[0]) begin
            grant    = '0;
            grant[0] = 1'b1;
            win      = '0;
        end
`endif
    end

    assign grant_en   = rst && (state != DRAIN) && !flush;
    assign req_ready  = grant_en ? grant : '0;
    assign xfer       = grant_en && (|grant);
    assign busy       = |tag_v;
    assign drain_done = (state == DRAIN) && !(|tag_v);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            adder_in  <= '0;
            tag_v     <= '0;
            rsp_valid <= '0;
            rsp_sum   <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tag_id[i] <= '0;
        end else begin
            adder_in <= xfer ? req_data[win*VW +: VW] : '0;
            tag_v    <= {tag_v[DEPTH-2:0], xfer};
            tag_id[0] <= win;
            for (int i = 1; i < DEPTH; i++) tag_id[i] <= tag_id[i-1];

`ifdef ADDER27_SCHED_PRIO_EN
            if (xfer && win != '0)
`else
            if (xfer)
`endif
                ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

            rsp_valid <= '0;
            if (tag_v[DEPTH-1]) begin
                rsp_valid[tag_id[DEPTH-1]] <= 1'b1;
                rsp_sum <= adder_sum;
                if (!adder_valid) err_q <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (flush) state <= DRAIN;
                    else if (xfer) state <= BUSY;
                end
                BUSY: begin
                    if (flush) state <= DRAIN;
                    else if (!xfer && tag_v[DEPTH-2:0] == '0) state <= IDLE;
                end
                DRAIN: begin
                    if (!flush && !(|tag_v)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER27_SCHED_PRIO_EN
    assign err_lat = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_adder27_share_sched.sv
// Directed bench for adder27_share_sched with a behavioural 5-stage adder.
// Covers reset, latency, round-robin order, flush/drain and reset mid-flight.
module tb_adder27_share_sched;

    localparam int W  = 14;
    localparam int NI = 27;
    localparam int NR = 4;
    localparam int VW = NI * W;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*VW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [VW-1:0]     adder_in;
    logic [W-1:0]      adder_sum;
    logic              adder_valid;
    logic [NR-1:0]     rsp_valid;
    logic [W-1:0]      rsp_sum;
    logic              flush;
    logic              drain_done;
    logic              busy;
`ifdef ADDER27_SCHED_PRIO_EN
    logic              err_lat;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder27_share_sched #(
        .bitsize(W), .NUM_INPUTS(NI), .NUM_REQ(NR), .ADDER_LATENCY(5)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .adder_in(adder_in), .adder_sum(adder_sum), .adder_valid(adder_valid),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
        .flush(flush), .drain_done(drain_done), .busy(busy)
`ifdef ADDER27_SCHED_PRIO_EN
        , .err_lat(err_lat)
`endif
    );

    // Environment adder: sum sampled at each edge, output after 5 edges.
    logic [W-1:0] apipe [5];
    always @(posedge clk) begin
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < NI; k++) s = s + adder_in[k*W +: W];
        apipe[0] <= s;
        for (int i = 1; i < 5; i++) apipe[i] <= apipe[i-1];
    end
    assign adder_sum   = apipe[4];
    assign adder_valid = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int r, input int base, input int step);
        for (int k = 0; k < NI; k++)
            req_data[(r*NI+k)*W +: W] = W'(base + step*k);
    endtask

    int sums [4] = '{27, 54, 81, 108};

    initial begin
        rst = 1'b0; flush = 1'b0; req_valid = '1; req_data = '0;
        for (int r = 0; r < NR; r++) set_ops(r, r + 1, 0);

        // Reset hold with all requesters valid
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(req_ready), 64'h0);
            chk("rst_rsp", 64'(rsp_valid), 64'h0);
            chk("rst_adder_in", 64'(adder_in[63:0]), 64'h0);
            chk("rst_busy", 64'(busy), 64'h0);
        end
        rst = 1'b1; req_valid = '0;
        tick();

        // Single requester, operands 1..27 then 2,4..54
        set_ops(1, 1, 1);
        req_valid = 4'b0010; #1;
        chk("s1_ready", 64'(req_ready), 64'h2);
        tick(); req_valid = '0;
        chk("s1_adder_in0", 64'(adder_in[W-1:0]), 64'd1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) chk("s1_early", 64'(rsp_valid), 64'h0);
            else begin
                chk("s1_rsp", 64'(rsp_valid), 64'h2);
                chk("s1_sum", 64'(rsp_sum), 64'd378);
            end
        end
        set_ops(1, 2, 2);
        req_valid = 4'b0010;
        tick(); req_valid = '0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i < 6) chk("s2_early", 64'(rsp_valid), 64'h0);
            else begin
                chk("s2_rsp", 64'(rsp_valid), 64'h2);
                chk("s2_sum", 64'(rsp_sum), 64'd756);
            end
        end

        // Fairness from a fresh pointer
        rst = 1'b0; tick(); rst = 1'b1;
        for (int r = 0; r < NR; r++) set_ops(r, r + 1, 0);
        for (int c = 0; c < 14; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0; #1;
            if (c < 8) chk("rr_ready", 64'(req_ready), 64'(1 << (c % 4)));
            tick();
            if (c >= 6) begin
                chk("rr_rsp", 64'(rsp_valid), 64'(1 << ((c - 6) % 4)));
                chk("rr_sum", 64'(rsp_sum), 64'(sums[(c - 6) % 4]));
            end else chk("rr_quiet", 64'(rsp_valid), 64'h0);
        end
        tick();
        chk("rr_idle_busy", 64'(busy), 64'h0);

        // Flush after three back-to-back grants
        for (int c = 0; c < 10; c++) begin
            flush = (c >= 4);
            req_valid = (c == 3) ? 4'h0 : 4'hF; #1;
            if (c < 3) chk("fl_ready", 64'(req_ready), 64'(1 << c));
            else chk("fl_no_ready", 64'(req_ready), 64'h0);
            tick();
            if (c >= 6 && c <= 8) begin
                chk("fl_rsp", 64'(rsp_valid), 64'(1 << (c - 6)));
                chk("fl_sum", 64'(rsp_sum), 64'(sums[c - 6]));
            end else chk("fl_quiet", 64'(rsp_valid), 64'h0);
            if (c == 7) chk("fl_drain_lo", 64'(drain_done), 64'h0);
            if (c >= 8) chk("fl_drain_hi", 64'(drain_done), 64'h1);
        end
        flush = 1'b0; req_valid = '0;
        tick();
        chk("fl_exit_drain", 64'(drain_done), 64'h0);
        chk("fl_exit_busy", 64'(busy), 64'h0);
        req_valid = 4'b0100; #1;
        chk("fl_resume", 64'(req_ready), 64'h4);
        tick(); req_valid = '0;
        chk("fl_adder_in0", 64'(adder_in[W-1:0]), 64'd3);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 6) begin
                chk("fl_res_rsp", 64'(rsp_valid), 64'h4);
                chk("fl_res_sum", 64'(rsp_sum), 64'd81);
            end
        end

        // Reset mid-flight discards in-flight vectors
        req_valid = 4'b0011;
        tick(); tick();
        req_valid = '0;
        chk("mf_busy_pre", 64'(busy), 64'h1);
        tick();
        rst = 1'b0;
        tick();
        chk("mf_busy", 64'(busy), 64'h0);
        chk("mf_rsp0", 64'(rsp_valid), 64'h0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mf_no_rsp", 64'(rsp_valid), 64'h0);
        end

`ifdef ADDER27_SCHED_PRIO_EN
        // Requester 0 fixed priority over round-robin
        req_valid = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pr_req0", 64'(req_ready), 64'h1);
            tick();
        end
        req_valid = 4'b0100; #1;
        chk("pr_req2", 64'(req_ready), 64'h4);
        tick(); req_valid = '0;
        for (int i = 0; i < 8; i++) tick();
        chk("pr_err_lat", 64'(err_lat), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
